// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60 from a 50 MHz clock) and the
// colour type used between the renderer and the timing generator.
package vga_pkg;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24;
endpackage

// File: rtl/vga_timing_gen_if.sv
// Renderer/VGA-pin bundle of the timing generator; master is the generator.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic [23:0]        rgb_in;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               video_on;
  logic               pixel_tick;
  logic               frame_start;
  logic               vga_hs;
  logic               vga_vs;
  logic [7:0]         vga_r;
  logic [7:0]         vga_g;
  logic [7:0]         vga_b;

  modport master (
    input  rgb_in,
    output pixel_x, pixel_y, video_on, pixel_tick, frame_start,
    output vga_hs, vga_vs, vga_r, vga_g, vga_b
  );

  modport slave (
    output rgb_in,
    input  pixel_x, pixel_y, video_on, pixel_tick, frame_start,
    input  vga_hs, vga_vs, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_sync_counter.sv
// Pixel-rate divider plus horizontal/vertical raster counters; decodes the
// visible window and flags the wrap back to (0,0).
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = vga_pkg::CLK_DIV,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_TOTAL  = vga_pkg::V_TOTAL
) (
  input  logic               clock,
  input  logic               reset,
  output logic [COORD_W-1:0] h_cnt,
  output logic [COORD_W-1:0] v_cnt,
  output logic               pixel_tick,
  output logic               frame_start,
  output logic               video_on
);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);

  logic [DIV_W-1:0] div_cnt;
  logic             div_last;

  assign div_last = (div_cnt == DIV_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt    <= div_last ? '0 : div_cnt + 1'b1;
      pixel_tick <= div_last;
      // Raised together with the tick that carries the counters to (0,0).
      frame_start <= div_last && (h_cnt == H_LAST) && (v_cnt == V_LAST);
      if (pixel_tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);
endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: publishes the raster position and registers the
// renderer colour with HS/VS so every VGA pin changes on the same edge.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = vga_pkg::CLK_DIV,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  vga_timing_gen_if.master  bus
);
  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               pixel_tick;
  logic               frame_start;
  logic               video_on;
  logic               hs_on;
  logic               vs_on;
  logic               hs_q;
  logic               vs_q;
  rgb24               rgb_q;

  vga_sync_counter #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOT),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOT)
  ) u_counter (
    .clock       (clock),
    .reset       (reset),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .pixel_tick  (pixel_tick),
    .frame_start (frame_start),
    .video_on    (video_on)
  );

  always_comb begin
    hs_on = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_on = (v_cnt >= VS_START) && (v_cnt < VS_END);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      rgb_q <= '0;
    end else if (pixel_tick) begin
      hs_q  <= hs_on ? SYNC_POL : ~SYNC_POL;
      vs_q  <= vs_on ? SYNC_POL : ~SYNC_POL;
      rgb_q <= video_on ? rgb24'(bus.rgb_in) : '0;
    end
  end

  assign bus.pixel_x     = h_cnt;
  assign bus.pixel_y     = v_cnt;
  assign bus.video_on    = video_on;
  assign bus.pixel_tick  = pixel_tick;
  assign bus.frame_start = frame_start;
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_r       = rgb_q.r;
  assign bus.vga_g       = rgb_q.g;
  assign bus.vga_b       = rgb_q.b;
endmodule
